// File: rtl/vjtag_scan_pkg.sv
// rtl/vjtag_scan_pkg.sv - shared types and defaults for the virtual-JTAG scan master
package vjtag_scan_pkg;

  localparam int IR_WIDTH_DEF = 2;
  localparam int DR_WIDTH_DEF = 38;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Width of a counter that must hold 0..n-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vjtag_scan_master_if.sv
// rtl/vjtag_scan_master_if.sv - command/response handshake bundle of the scan master
interface vjtag_scan_master_if
  import vjtag_scan_pkg::*;
#(
  parameter int IR_WIDTH = IR_WIDTH_DEF,
  parameter int DR_WIDTH = DR_WIDTH_DEF
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_skip_ir;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IR_WIDTH-1:0] rsp_ir_out;
  logic [DR_WIDTH-1:0] rsp_dr;

  modport master (
    output cmd_valid, cmd_skip_ir, cmd_ir, cmd_dr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_ir_out, rsp_dr
  );

  modport slave (
    input  cmd_valid, cmd_skip_ir, cmd_ir, cmd_dr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_ir_out, rsp_dr
  );

endinterface

// File: rtl/vjtag_tck_gen.sv
// rtl/vjtag_tck_gen.sv - TCK divider with rise and phase-start pulses
module vjtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tck,
  output logic tck_rise,
  output logic phase_start
);

  localparam int CW = $clog2(2 * TCK_DIV);

  logic          run;
  logic [CW-1:0] cnt;

  // Pulses mark the clk edge at which TCK rises / falls into the next phase.
  assign tck_rise    = run && (cnt == CW'(TCK_DIV - 1));
  assign phase_start = run && (cnt == CW'(2 * TCK_DIV - 1));

  // One setup clk after enable before counting, so strobes and TDI settle ahead of TCK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= 1'b0;
      cnt <= '0;
      tck <= 1'b0;
    end else if (!enable) begin
      run <= 1'b0;
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) begin
        cnt <= phase_start ? '0 : cnt + 1'b1;
        if (tck_rise)
          tck <= 1'b1;
        else if (phase_start)
          tck <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vjtag_scan_master.sv
// rtl/vjtag_scan_master.sv - virtual-JTAG initiator: IR/DR command to vji_* pin sequence
module vjtag_scan_master
  import vjtag_scan_pkg::*;
#(
  parameter int IR_WIDTH = IR_WIDTH_DEF,
  parameter int DR_WIDTH = DR_WIDTH_DEF,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  vjtag_scan_master_if.slave  bus,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int CW = cnt_width(DR_WIDTH);

  state_e              state;
  logic [DR_WIDTH-1:0] shift_q;
  logic [DR_WIDTH-1:0] capture_q;
  logic [CW-1:0]       bit_cnt;
  logic [IR_WIDTH-1:0] ir_q;
  logic [IR_WIDTH-1:0] ir_out_q;
  logic                tdi_q;
  logic                scan_en;
  logic                tck_rise;
  logic                phase_start;
  logic                last_bit;

  assign scan_en  = (state != ST_IDLE) && (state != ST_DONE);
  assign last_bit = (bit_cnt == CW'(DR_WIDTH - 1));

  vjtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk         (clk),
    .reset       (reset),
    .enable      (scan_en),
    .tck         (vji_tck),
    .tck_rise    (tck_rise),
    .phase_start (phase_start)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      shift_q   <= '0;
      capture_q <= '0;
      bit_cnt   <= '0;
      ir_q      <= '0;
      ir_out_q  <= '0;
      tdi_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            shift_q <= bus.cmd_dr;
            if (bus.cmd_skip_ir) begin
              state <= ST_CDR;
            end else begin
              ir_q  <= bus.cmd_ir;
              state <= ST_UIR;
            end
          end
        end
        ST_UIR: if (phase_start) state <= ST_CDR;
        ST_CDR: begin
          if (phase_start) begin
            state   <= ST_SDR;
            bit_cnt <= '0;
            tdi_q   <= shift_q[0];
          end
        end
        ST_SDR: begin
          if (tck_rise) begin
            capture_q <= {vji_tdo, capture_q[DR_WIDTH-1:1]};
            shift_q   <= shift_q >> 1;
          end
          // TDI is re-registered only at bit start so it never moves while TCK is high.
          if (phase_start) begin
            if (last_bit) begin
              state <= ST_UDR;
              tdi_q <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tdi_q   <= shift_q[0];
            end
          end
        end
        ST_UDR: begin
          if (tck_rise)    ir_out_q <= vji_ir_out;
          if (phase_start) state    <= ST_DONE;
        end
        ST_DONE: if (bus.rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = (state == ST_IDLE);
  assign bus.rsp_valid  = (state == ST_DONE);
  assign bus.rsp_dr     = capture_q;
  assign bus.rsp_ir_out = ir_out_q;

  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_q;
  assign vji_uir   = (state == ST_UIR);
  assign vji_cdr   = (state == ST_CDR);
  assign vji_sdr   = (state == ST_SDR);
  assign vji_udr   = (state == ST_UDR);
  assign vji_rti   = !scan_en;

endmodule

// File: tb/tb_vjtag_scan_master.sv
// tb/tb_vjtag_scan_master.sv - self-checking bench for vjtag_scan_master
module tb_vjtag_scan_master;

  localparam int IRW  = 2;
  localparam int DRW  = 38;
  localparam int DIV  = 2;
  localparam int DRW1 = 8;
  localparam int DIV1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  vjtag_scan_master_if #(.IR_WIDTH(IRW), .DR_WIDTH(DRW))  bus0 ();
  vjtag_scan_master_if #(.IR_WIDTH(IRW), .DR_WIDTH(DRW1)) bus1 ();

  logic           tck0, tdi0, tdo0, uir0, cdr0, sdr0, udr0, rti0;
  logic [IRW-1:0] ir_in0, ir_out0;
  logic           tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;
  logic [IRW-1:0] ir_in1, ir_out1;

  vjtag_scan_master #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .TCK_DIV(DIV)) dut0 (
    .clk(clk), .reset(rst), .bus(bus0),
    .vji_tck(tck0), .vji_tdi(tdi0), .vji_tdo(tdo0),
    .vji_ir_in(ir_in0), .vji_ir_out(ir_out0),
    .vji_uir(uir0), .vji_cdr(cdr0), .vji_sdr(sdr0), .vji_udr(udr0), .vji_rti(rti0)
  );

  vjtag_scan_master #(.IR_WIDTH(IRW), .DR_WIDTH(DRW1), .TCK_DIV(DIV1)) dut1 (
    .clk(clk), .reset(rst), .bus(bus1),
    .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo1),
    .vji_ir_in(ir_in1), .vji_ir_out(ir_out1),
    .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1)
  );

  // Target data registers: tdo is the low bit, tdi enters at the top on each sdr TCK rise.
  logic [DRW-1:0]  sr0, ld_val0;
  logic [DRW1-1:0] sr1, ld_val1;
  logic ld0 = 1'b0, ld1 = 1'b0;
  always @(posedge tck0 or posedge ld0)
    if (ld0) sr0 <= ld_val0; else if (sdr0) sr0 <= {tdi0, sr0[DRW-1:1]};
  always @(posedge tck1 or posedge ld1)
    if (ld1) sr1 <= ld_val1; else if (sdr1) sr1 <= {tdi1, sr1[DRW1-1:1]};
  assign tdo0 = sr0[0];
  assign tdo1 = sr1[0];

  int n_uir0 = 0, n_sdr0 = 0, n_udr0 = 0, n_hi0 = 0, bad0 = 0;
  int n_uir1 = 0, n_sdr1 = 0, n_udr1 = 0, n_hi1 = 0, bad1 = 0;
  always @(posedge tck0) begin
    if (uir0) n_uir0++;
    if (sdr0) n_sdr0++;
    if (udr0) n_udr0++;
  end
  always @(posedge tck1) begin
    if (uir1) n_uir1++;
    if (sdr1) n_sdr1++;
    if (udr1) n_udr1++;
  end
  always @(posedge clk) begin
    if (tck0) n_hi0++;
    if (tck1) n_hi1++;
  end
  always @(negedge clk) begin
    if (!rst && ($countones({uir0, cdr0, sdr0, udr0, rti0}) != 1)) bad0++;
    if (!rst && ($countones({uir1, cdr1, sdr1, udr1, rti1}) != 1)) bad1++;
  end

  logic [1:0] cur_ir [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic rv(input int u);
    return (u == 0) ? bus0.rsp_valid : bus1.rsp_valid;
  endfunction

  // One full command on unit u; expected values come from the loopback target rule.
  task automatic do_cmd(input int u, input bit skip, input logic [1:0] ir,
                        input logic [63:0] dr_in, input logic [1:0] iro,
                        input int hold, input string tag);
    int w, dv, n_tck, exp_lat, lat, b_uir, b_sdr, b_udr, b_hi;
    logic [63:0] mask, dr, exp_rsp, obs_dr;
    logic [1:0]  exp_ir;
    logic        rdy;
    w       = (u == 0) ? DRW : DRW1;
    dv      = (u == 0) ? DIV : DIV1;
    mask    = (64'd1 << w) - 64'd1;
    dr      = dr_in & mask;
    exp_rsp = (u == 0) ? 64'(sr0) : 64'(sr1);
    if (!skip) cur_ir[u] = ir;
    exp_ir  = cur_ir[u];
    n_tck   = w + (skip ? 2 : 3);
    exp_lat = n_tck * 2 * dv + 1;
    b_uir   = (u == 0) ? n_uir0 : n_uir1;
    b_sdr   = (u == 0) ? n_sdr0 : n_sdr1;
    b_udr   = (u == 0) ? n_udr0 : n_udr1;
    b_hi    = (u == 0) ? n_hi0  : n_hi1;
    if (u == 0) begin
      bus0.cmd_skip_ir = skip; bus0.cmd_ir = ir; bus0.cmd_dr = dr[DRW-1:0];
      bus0.cmd_valid = 1'b1; ir_out0 = iro; rdy = bus0.cmd_ready;
    end else begin
      bus1.cmd_skip_ir = skip; bus1.cmd_ir = ir; bus1.cmd_dr = dr[DRW1-1:0];
      bus1.cmd_valid = 1'b1; ir_out1 = iro; rdy = bus1.cmd_ready;
    end
    @(posedge clk); #1;
    bus0.cmd_valid = 1'b0;
    bus1.cmd_valid = 1'b0;
    chk({tag, "/accept_ready"}, 64'(rdy), 64'd1);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!rv(u) && lat < 2000);
    obs_dr = (u == 0) ? 64'(bus0.rsp_dr) : 64'(bus1.rsp_dr);
    chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "/rsp_dr"}, obs_dr, exp_rsp);
    chk({tag, "/rsp_ir_out"}, 64'((u == 0) ? bus0.rsp_ir_out : bus1.rsp_ir_out), 64'(iro));
    chk({tag, "/ir_in"}, 64'((u == 0) ? ir_in0 : ir_in1), 64'(exp_ir));
    chk({tag, "/target_sr"}, (u == 0) ? 64'(sr0) : 64'(sr1), dr);
    chk({tag, "/uir_edges"}, 64'(((u == 0) ? n_uir0 : n_uir1) - b_uir), skip ? 64'd0 : 64'd1);
    chk({tag, "/sdr_edges"}, 64'(((u == 0) ? n_sdr0 : n_sdr1) - b_sdr), 64'(w));
    chk({tag, "/udr_edges"}, 64'(((u == 0) ? n_udr0 : n_udr1) - b_udr), 64'd1);
    chk({tag, "/tck_high_clks"}, 64'(((u == 0) ? n_hi0 : n_hi1) - b_hi), 64'(n_tck * dv));
    chk({tag, "/done_ready"}, 64'((u == 0) ? bus0.cmd_ready : bus1.cmd_ready), 64'd0);
    chk({tag, "/done_tck"}, 64'((u == 0) ? tck0 : tck1), 64'd0);
    if (hold > 0) begin
      // Offer a conflicting command while the response waits; it must be dropped.
      if (u == 0) begin bus0.cmd_ir = ~ir; bus0.cmd_skip_ir = 1'b0; bus0.cmd_valid = 1'b1; end
      else        begin bus1.cmd_ir = ~ir; bus1.cmd_skip_ir = 1'b0; bus1.cmd_valid = 1'b1; end
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "/hold_valid"}, 64'(rv(u)), 64'd1);
      chk({tag, "/hold_dr"}, (u == 0) ? 64'(bus0.rsp_dr) : 64'(bus1.rsp_dr), exp_rsp);
      chk({tag, "/hold_ir_out"}, 64'((u == 0) ? bus0.rsp_ir_out : bus1.rsp_ir_out), 64'(iro));
      chk({tag, "/hold_ready"}, 64'((u == 0) ? bus0.cmd_ready : bus1.cmd_ready), 64'd0);
    end
    bus0.rsp_ready = (u == 0);
    bus1.rsp_ready = (u == 1);
    @(posedge clk); #1;
    bus0.rsp_ready = 1'b0; bus1.rsp_ready = 1'b0;
    bus0.cmd_valid = 1'b0; bus1.cmd_valid = 1'b0;
    chk({tag, "/consumed"}, 64'(rv(u)), 64'd0);
    chk({tag, "/idle_ready"}, 64'((u == 0) ? bus0.cmd_ready : bus1.cmd_ready), 64'd1);
    chk({tag, "/ir_in_kept"}, 64'((u == 0) ? ir_in0 : ir_in1), 64'(exp_ir));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt, base, hi_seen;
    logic [63:0] rdr;
    bus0.cmd_valid = 1'b0; bus0.cmd_skip_ir = 1'b0; bus0.cmd_ir = '0; bus0.cmd_dr = '0; bus0.rsp_ready = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_skip_ir = 1'b0; bus1.cmd_ir = '0; bus1.cmd_dr = '0; bus1.rsp_ready = 1'b0;
    ir_out0 = '0; ir_out1 = '0;
    cur_ir[0] = 2'b00; cur_ir[1] = 2'b00;
    ld_val0 = 38'h15_AAAA_AAAA; ld_val1 = 8'hC3;
    #1; ld0 = 1'b1; ld1 = 1'b1; #1; ld0 = 1'b0; ld1 = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1;

    chk("reset/cmd_ready", 64'(bus0.cmd_ready), 64'd1);
    chk("reset/rti", 64'(rti0), 64'd1);
    chk("reset/tck", 64'(tck0), 64'd0);
    chk("reset/tdi", 64'(tdi0), 64'd0);
    chk("reset/strobes", 64'({uir0, cdr0, sdr0, udr0}), 64'd0);
    chk("reset/ir_in", 64'(ir_in0), 64'd0);
    chk("reset/rsp_valid", 64'(bus0.rsp_valid), 64'd0);
    chk("reset/rsp_dr", 64'(bus0.rsp_dr), 64'd0);
    chk("reset/rsp_ir_out", 64'(bus0.rsp_ir_out), 64'd0);

    do_cmd(0, 1'b0, 2'b01, 64'h2A_5555_5555, 2'b10, 10, "directed");
    do_cmd(0, 1'b1, 2'b10, 64'h3F_0F0F_1234, 2'b11, 0, "skip_ir");

    // Abort a scan part-way through SDR.
    base = n_sdr0;
    bus0.cmd_skip_ir = 1'b0; bus0.cmd_ir = 2'b11; bus0.cmd_dr = 38'h01_2345_6789;
    bus0.cmd_valid = 1'b1;
    @(posedge clk); #1; bus0.cmd_valid = 1'b0;
    cnt = 0;
    while ((n_sdr0 - base) < 20 && cnt < 2000) begin
      @(posedge clk); #1; cnt++;
    end
    chk("abort/reach_bit20", 64'(n_sdr0 - base), 64'd20);
    @(negedge clk); rst = 1'b1; #1;
    chk("abort/tck", 64'(tck0), 64'd0);
    chk("abort/sdr", 64'(sdr0), 64'd0);
    chk("abort/ir_in", 64'(ir_in0), 64'd0);
    chk("abort/rti", 64'(rti0), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    cur_ir[0] = 2'b00; cur_ir[1] = 2'b00;
    hi_seen = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (bus0.rsp_valid) hi_seen++;
    end
    chk("abort/no_response", 64'(hi_seen), 64'd0);
    do_cmd(0, 1'b0, 2'b10, 64'h15_0000_FFFF, 2'b01, 0, "after_abort");

    for (int k = 0; k < 6; k++) begin
      rdr = {$urandom, $urandom};
      do_cmd(0, 1'($urandom_range(0, 1)), 2'($urandom), rdr, 2'($urandom),
             int'($urandom_range(0, 2)), "rand0");
    end

    do_cmd(1, 1'b0, 2'b11, 64'h5A, 2'b01, 0, "div1");
    for (int k = 0; k < 4; k++) begin
      rdr = {$urandom, $urandom};
      do_cmd(1, 1'($urandom_range(0, 1)), 2'($urandom), rdr, 2'($urandom), 1, "rand1");
    end

    chk("strobe_onehot0", 64'(bad0), 64'd0);
    chk("strobe_onehot1", 64'(bad1), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
